dma_wb_scheduler: RTL



---
 rtl/dma_wb_scheduler_pkg.sv | 19 +
 rtl/dma_wb_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dma_wb_scheduler_pkg.sv
// Shared types and constants for the DMA write-back scheduler.
// The optional DMA_WB_PERF_EN feature adds no package content.
package dma_wb_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_e;

    localparam int BEAT_BYTES      = 8;
    localparam int BEAT_SHIFT      = 3;
    localparam int DEF_BURST_BEATS = 256;
    localparam int DEF_GAP_CYCLES  = 4;

endpackage

// File: rtl/dma_wb_scheduler.sv
// Splits one buffer write-back job into DMA master bursts.
// Define DMA_WB_PERF_EN to add the perf_cycles / perf_bursts counters.
module dma_wb_scheduler
    import dma_wb_scheduler_pkg::*;
#(
    parameter int ADDR_BIT    = 16,
    parameter int BURST_BEATS = DEF_BURST_BEATS,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [31:0]         job_ddr_addr,
    input  logic [ADDR_BIT:0]   job_buf_start,
    input  logic [ADDR_BIT:0]   job_beats,
    output logic                job_done,
    output logic                busy,
    output logic                send_enable,
    input  logic                send_done,
    output logic [31:0]         dma_addr,
    output logic [15:0]         dma_len,
    output logic [ADDR_BIT:0]   addr_start,
    output logic [ADDR_BIT:0]   addr_end
`ifdef DMA_WB_PERF_EN
    ,
    output logic [31:0]         perf_cycles,
    output logic [15:0]         perf_bursts
`endif
);

    localparam int AW = ADDR_BIT + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [AW-1:0] BURST_MAX = AW'(BURST_BEATS);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    state_e          state_q;
    logic [AW-1:0]   rem_q;
    logic [AW-1:0]   cur_buf_q;
    logic [31:0]     cur_ddr_q;
    logic [AW-1:0]   burst_q;
    logic [GW-1:0]   gap_q;
    logic            job_ready_q;
    logic            job_done_q;
    logic            busy_q;
    logic            send_enable_q;
    logic [31:0]     dma_addr_q;
    logic [15:0]     dma_len_q;
    logic [AW-1:0]   addr_start_q;
    logic [AW-1:0]   addr_end_q;

    logic [AW-1:0]   burst_d;
    logic [15:0]     len_d;
    logic            accept;

    assign accept = (state_q == S_IDLE) && job_valid && job_ready_q;

    always_comb begin
        burst_d = (rem_q > BURST_MAX) ? BURST_MAX : rem_q;
        len_d   = 16'(burst_d) << BEAT_SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            cur_buf_q     <= '0;
            cur_ddr_q     <= '0;
            burst_q       <= '0;
            gap_q         <= '0;
            job_ready_q   <= 1'b1;
            job_done_q    <= 1'b0;
            busy_q        <= 1'b0;
            send_enable_q <= 1'b0;
            dma_addr_q    <= '0;
            dma_len_q     <= '0;
            addr_start_q  <= '0;
            addr_end_q    <= '0;
        end else begin
            job_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rem_q       <= job_beats;
                        cur_buf_q   <= job_buf_start;
                        cur_ddr_q   <= job_ddr_addr;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (job_beats == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    burst_q      <= burst_d;
                    addr_start_q <= cur_buf_q;
                    addr_end_q   <= cur_buf_q + burst_d;
                    dma_len_q    <= len_d;
                    dma_addr_q   <= cur_ddr_q;
                    state_q      <= S_ISSUE;
                end
                S_ISSUE: begin
                    send_enable_q <= 1'b1;
                    gap_q         <= '0;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    if (send_done) begin
                        send_enable_q <= 1'b0;
                        rem_q         <= rem_q - burst_q;
                        cur_buf_q     <= cur_buf_q + burst_q;
                        cur_ddr_q     <= cur_ddr_q + {16'd0, dma_len_q};
                        state_q       <= (rem_q == burst_q) ? S_DONE : S_GAP;
                    end
                end
                S_GAP: begin
                    // Keeps enable low long enough for the master's edge detector
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= S_LOAD;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_DONE: begin
                    job_done_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    job_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ready   = job_ready_q;
    assign job_done    = job_done_q;
    assign busy        = busy_q;
    assign send_enable = send_enable_q;
    assign dma_addr    = dma_addr_q;
    assign dma_len     = dma_len_q;
    assign addr_start  = addr_start_q;
    assign addr_end    = addr_end_q;

`ifdef DMA_WB_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [15:0] perf_bursts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_bursts_q <= '0;
        end else if (accept) begin
            perf_cycles_q <= '0;
            perf_bursts_q <= '0;
        end else begin
            if (state_q != S_IDLE) begin
                perf_cycles_q <= perf_cycles_q + 1'b1;
            end
            if ((state_q == S_WAIT) && send_done) begin
                perf_bursts_q <= perf_bursts_q + 1'b1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_bursts = perf_bursts_q;
`endif

endmodule
